sc_mul_accum: RTL and testbench

//  Downstream stage of the 8-bit stochastic multiplier top. Consumes its 16-bit

---
 rtl/sc_pkg.sv | 12 +
 rtl/sc_mul_accum_if.sv | 30 +++
 rtl/sc_acc_add.sv | 25 ++
 rtl/sc_mul_accum.sv | 101 ++++++++++
 tb/tb_sc_mul_accum.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// Shared types and default widths for the stochastic multiplier datapath.
package sc_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam int SC_PROD_WIDTH = 16;
  localparam int SC_ACC_WIDTH  = 24;

endpackage

// File: rtl/sc_mul_accum_if.sv
// Input product stream and output result stream of the accumulate stage.
interface sc_mul_accum_if
  import sc_pkg::*;
#(
  parameter int PROD_WIDTH = SC_PROD_WIDTH,
  parameter int ACC_WIDTH  = SC_ACC_WIDTH,
  parameter int CNT_WIDTH  = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic [PROD_WIDTH-1:0] in_product;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_sum;
  logic [CNT_WIDTH-1:0]  out_count;
  logic                  out_ovf;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/sc_acc_add.sv
// Accumulator adder with carry-out; clamps on carry when
// SC_MUL_ACCUM_SAT_EN is defined, otherwise wraps.
module sc_acc_add #(
  parameter int PROD_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic [PROD_WIDTH-1:0] prod_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic                  carry_o
);

  logic [ACC_WIDTH:0] wide;

  always_comb begin
    wide    = {1'b0, acc_i} + (ACC_WIDTH+1)'(prod_i);
    carry_o = wide[ACC_WIDTH];
`ifdef SC_MUL_ACCUM_SAT_EN
    sum_o   = carry_o ? '1 : wide[ACC_WIDTH-1:0];
`else
    sum_o   = wide[ACC_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/sc_mul_accum.sv
// Burst dot-product accumulator behind the stochastic multiplier.
// Optional saturation: SC_MUL_ACCUM_SAT_EN.
module sc_mul_accum
  import sc_pkg::*;
#(
  parameter int PROD_WIDTH = SC_PROD_WIDTH,
  parameter int ACC_WIDTH  = SC_ACC_WIDTH,
  parameter int MAX_TERMS  = 16,
  parameter int CNT_WIDTH  = 5
) (
  input logic           clk,
  input logic           rst_n,
  sc_mul_accum_if.slave bus
);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 oovf_q, oovf_d;

  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_carry;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 ovf_nxt;

  sc_acc_add #(
    .PROD_WIDTH (PROD_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_add (
    .acc_i   (acc_q),
    .prod_i  (bus.in_product),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    count_d = count_q;
    oovf_d  = oovf_q;
    cnt_inc = cnt_q + 1'b1;
    ovf_nxt = ovf_q | add_carry;
    unique case (state_q)
      ST_ACCUM: begin
        if (bus.in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_nxt;
          // in_last on the final allowed term is one burst end
          if (bus.in_last ||
              cnt_inc == CNT_WIDTH'(MAX_TERMS)) begin
            sum_d   = add_sum;
            count_d = cnt_inc;
            oovf_d  = ovf_nxt;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      oovf_q  <= oovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = oovf_q;

endmodule

// File: tb/tb_sc_mul_accum.sv
// Scoreboard bench: one stimulus stream drives a 24-bit and a 17-bit
// accumulator; expected results come from whole-burst arithmetic.
module tb_sc_mul_accum;

  localparam int MAXT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_mul_accum_if #(.ACC_WIDTH(24)) if24 ();
  sc_mul_accum_if #(.ACC_WIDTH(17)) if17 ();

  assign if17.in_valid   = if24.in_valid;
  assign if17.in_product = if24.in_product;
  assign if17.in_last    = if24.in_last;
  assign if17.out_ready  = if24.out_ready;

  sc_mul_accum #(.ACC_WIDTH(24)) u24 (
    .clk(clk), .rst_n(rst_n), .bus(if24.slave));
  sc_mul_accum #(.ACC_WIDTH(17)) u17 (
    .clk(clk), .rst_n(rst_n), .bus(if17.slave));

  typedef struct {
    logic [23:0] s24;
    logic        o24;
    logic [16:0] s17;
    logic        o17;
    logic [4:0]  cnt;
  } exp_t;

  exp_t   sb[$];
  int     n_vec = 0;
  int     n_err = 0;
  longint tot = 0;
  int     bcnt = 0;
  logic   rnd_ready = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void fold(input longint t, input int w,
                               output logic [31:0] s,
                               output logic o);
    longint m;
    m = longint'(1) << w;
    o = (t >= m);
`ifdef SC_MUL_ACCUM_SAT_EN
    s = o ? 32'(m - 1) : 32'(t);
`else
    s = 32'(t % m);
`endif
  endfunction

  task automatic model_term(input logic [15:0] p, input logic last,
                            output logic ended);
    exp_t e;
    logic [31:0] s;
    logic o;
    tot += longint'(p);
    bcnt++;
    ended = last || (bcnt == MAXT);
    if (ended) begin
      fold(tot, 24, s, o); e.s24 = s[23:0]; e.o24 = o;
      fold(tot, 17, s, o); e.s17 = s[16:0]; e.o17 = o;
      e.cnt = 5'(bcnt);
      sb.push_back(e);
      tot = 0;
      bcnt = 0;
    end
  endtask

  task automatic send(input logic [15:0] p, input logic last);
    logic ok;
    logic ended;
    int n;
    ok = 1'b0;
    n = 0;
    if24.in_valid   = 1'b1;
    if24.in_product = p;
    if24.in_last    = last;
    while (!ok && n < 64) begin
      ok = if24.in_ready;
      @(posedge clk); #1;
      n++;
    end
    if24.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    else begin
      model_term(p, last, ended);
      if (ended) chk("result_latency", 32'(if24.out_valid), 32'd1);
    end
  endtask

  // Monitor: pop on each result transfer, check hold stability.
  logic        held = 1'b0;
  logic [23:0] h_sum;
  logic [4:0]  h_cnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      held <= 1'b0;
    end else begin
      chk("in_ready_vs_valid", 32'(if24.in_ready),
          32'(!if24.out_valid));
      if (if24.out_valid) begin
        if (held) begin
          chk("hold_sum", 32'(if24.out_sum), 32'(h_sum));
          chk("hold_cnt", 32'(if24.out_count), 32'(h_cnt));
        end
        if (if24.out_ready) begin
          if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("sum24", 32'(if24.out_sum), 32'(e.s24));
            chk("ovf24", 32'(if24.out_ovf), 32'(e.o24));
            chk("cnt24", 32'(if24.out_count), 32'(e.cnt));
            chk("sum17", 32'(if17.out_sum), 32'(e.s17));
            chk("ovf17", 32'(if17.out_ovf), 32'(e.o17));
            chk("cnt17", 32'(if17.out_count), 32'(e.cnt));
          end
        end
        held  <= !if24.out_ready;
        h_sum <= if24.out_sum;
        h_cnt <= if24.out_count;
      end else begin
        held <= 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) if24.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int len;
    int n;
    logic [15:0] p;
    logic [23:0] snap;
    if24.in_valid   = 1'b1;
    if24.in_product = 16'h1234;
    if24.in_last    = 1'b1;
    if24.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    if24.in_valid = 1'b0;
    chk("rst_in_ready", 32'(if24.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if24.out_valid), 32'd0);
    chk("rst_out_sum", 32'(if24.out_sum), 32'd0);
    chk("rst_out_count", 32'(if24.out_count), 32'd0);
    chk("rst_out_ovf", 32'(if24.out_ovf), 32'd0);

    send(16'd3, 1'b0);
    send(16'd5, 1'b0);
    send(16'd7, 1'b1);
    @(posedge clk); #1;
    chk("valid_drops", 32'(if24.out_valid), 32'd0);

    for (int i = 0; i < 16; i++) send(16'hFFFF, 1'b0);
    @(posedge clk); #1;

    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b1);
    @(posedge clk); #1;

    if24.out_ready = 1'b0;
    send(16'd9, 1'b1);
    snap = if24.out_sum;
    chk("bp_sum", 32'(snap), 32'd9);
    if24.in_valid   = 1'b1;
    if24.in_product = 16'd11;
    if24.in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(if24.in_ready), 32'd0);
      chk("bp_stable", 32'(if24.out_sum), 32'(snap));
      @(posedge clk); #1;
    end
    if24.out_ready = 1'b1;
    send(16'd11, 1'b1);
    @(posedge clk); #1;

    send(16'd10, 1'b0);
    send(16'd20, 1'b0);
    rst_n = 1'b0;
    tot = 0;
    bcnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_valid", 32'(if24.out_valid), 32'd0);
    chk("midrst_ready", 32'(if24.in_ready), 32'd1);
    send(16'd4, 1'b1);
    @(posedge clk); #1;

    rnd_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      len = $urandom_range(1, 20);
      for (int t = 0; t < len; t++) begin
        p = ($urandom_range(0, 1) == 1) ? 16'hFFFF - 16'($urandom_range(0, 15))
                                        : 16'($urandom);
        send(p, t == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    rnd_ready = 1'b0;
    #1 if24.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
